// File: rtl/tail_bytes_capture_pkg.sv
// -----------------------------------------------------------------------------
// tail_bytes_capture_pkg
// Shared widths and types for the tail-byte capture tap that feeds
// data_shift's last_7_bytes port.
//   FLIT_W     : width of one packet-stream flit
//   EMPTY_W    : width of the "unused bytes" count on the last flit
//   TAIL_BYTES : number of trailing bytes kept per packet
//   TAIL_W     : width of one tail record
//   WINDOW_W   : previous-tail bytes concatenated with the current flit
// -----------------------------------------------------------------------------
package tail_bytes_capture_pkg;

  localparam int FLIT_W     = 256;
  localparam int EMPTY_W    = 5;
  localparam int TAIL_BYTES = 7;
  localparam int TAIL_W     = TAIL_BYTES * 8;
  localparam int WINDOW_W   = TAIL_W + FLIT_W;

  // Sideband of one flit, grouped so the top can name it as a unit.
  typedef struct packed {
    logic               sop;
    logic               eop;
    logic [EMPTY_W-1:0] empty;
  } flit_ctrl_s;

  // A tail record made entirely of the fill byte.
  function automatic logic [TAIL_W-1:0] pad_record(input logic [7:0] pad_byte);
    return {TAIL_BYTES{pad_byte}};
  endfunction

endpackage

// File: rtl/tail_bytes_capture_fifo.sv
// -----------------------------------------------------------------------------
// tail_fifo
// Small synchronous FIFO for tail records. Storage is registered, the read
// port is combinational (rd_data = mem[rd_ptr]). Reset leaves exactly one
// entry in the FIFO, the value on 'seed', so the very first consumer pop
// always finds data.
//   clk, rst_n : clock, asynchronous active-low reset
//   seed       : record preloaded into entry 0 during reset (tie to a constant)
//   push       : write push_data (ignored while full)
//   push_data  : record to write
//   pop_req    : consumer pop request (ignored while empty)
//   rd_data    : record at the head of the FIFO
//   rd_valid   : FIFO not empty
//   not_full   : FIFO can take another record
// DEPTH must be a power of two and at least 2; the pointers wrap by natural
// binary overflow.
// -----------------------------------------------------------------------------
module tail_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 56
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] seed,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             not_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             wr_en;
  logic             rd_en;

  // Both strobes are qualified here so a push while full or a pop while
  // empty can never corrupt the pointers or the count.
  assign wr_en    = push & not_full;
  assign rd_en    = pop_req & rd_valid;
  assign rd_valid = (count != '0);
  assign not_full = (count < CNT_W'(DEPTH));
  assign rd_data  = mem[rd_ptr];

  // Storage: every entry is loaded with the seed in reset, which makes the
  // head entry (index 0) the preloaded record; the others are overwritten
  // before they are ever read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= seed;
      end
    end else if (wr_en) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy: reset starts with one entry already present,
  // so the write pointer sits one slot ahead of the read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= PTR_W'(1);
      rd_ptr <= '0;
      count  <= CNT_W'(1);
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tail_bytes_capture.sv
// -----------------------------------------------------------------------------
// tail_bytes_capture
// Stream tap in front of data_shift. For each packet on the 256-bit stream it
// extracts the final 7 bytes and queues them, so data_shift can prepend them
// to the next packet's first flit and catch patterns that straddle packets.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_pkt_sop/eop      : first / last flit of a packet
//   in_pkt_valid        : flit valid
//   in_pkt_data         : flit, packet byte 0 in bits [255:248]
//   in_pkt_empty        : unused bytes at the LSB end (eop flits only)
//   in_pkt_ready        : a flit can be accepted (FIFO not full)
//   last_7_bytes        : head tail record, bits [7:0] = final packet byte
//   last_7_bytes_valid  : a tail record is available
//   last_7_bytes_ready  : consumer pops the head record
// -----------------------------------------------------------------------------
module tail_bytes_capture
  import tail_bytes_capture_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] PAD_BYTE = 8'hff
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_pkt_sop,
  input  logic               in_pkt_eop,
  input  logic               in_pkt_valid,
  input  logic [FLIT_W-1:0]  in_pkt_data,
  input  logic [EMPTY_W-1:0] in_pkt_empty,
  output logic               in_pkt_ready,
  output logic [TAIL_W-1:0]  last_7_bytes,
  output logic               last_7_bytes_valid,
  input  logic               last_7_bytes_ready
);

  localparam logic [TAIL_W-1:0] PAD_REC = {TAIL_BYTES{PAD_BYTE}};

  flit_ctrl_s            ctrl;
  logic                  accept;
  logic [TAIL_W-1:0]     prev_tail;
  logic [TAIL_W-1:0]     prev_or_pad;
  logic [WINDOW_W-1:0]   window;
  logic [8:0]            shift;
  logic [TAIL_W-1:0]     tail;

  assign ctrl   = '{sop: in_pkt_sop, eop: in_pkt_eop, empty: in_pkt_empty};
  assign accept = in_pkt_valid & in_pkt_ready;

  // A sop always starts from pad bytes, so a packet that never saw its eop
  // cannot leak its bytes into the next packet's record.
  assign prev_or_pad = ctrl.sop ? PAD_REC : prev_tail;

  // The window is the last 7 bytes before this flit followed by the flit.
  // Skipping 'empty' unused bytes from the LSB end leaves the packet's final
  // 7 bytes at the bottom; with empty <= 31 the slice stays inside the window.
  assign window = {prev_or_pad, in_pkt_data};
  assign shift  = {1'b0, ctrl.empty, 3'b000};
  assign tail   = window[shift +: TAIL_W];

  // Carry the low 7 bytes of each mid-packet flit forward; after an eop the
  // next packet starts from pad again.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_tail <= PAD_REC;
    end else if (accept) begin
      prev_tail <= ctrl.eop ? PAD_REC : in_pkt_data[TAIL_W-1:0];
    end
  end

  // in_pkt_ready comes straight from the FIFO's registered count, so there
  // is no combinational path from the stream inputs to the ready output.
  tail_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (TAIL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed      (pad_record(PAD_BYTE)),
    .push      (accept & ctrl.eop),
    .push_data (tail),
    .pop_req   (last_7_bytes_ready),
    .rd_data   (last_7_bytes),
    .rd_valid  (last_7_bytes_valid),
    .not_full  (in_pkt_ready)
  );

endmodule

// File: tb/tb_tail_bytes_capture.sv
// -----------------------------------------------------------------------------
// tb_tail_bytes_capture
// Scenario tasks drive the stream and the consumer pop. Every packet end
// pushes its expected tail record onto a scoreboard queue when driven; every
// consumer pop compares the DUT head record with the front of the queue.
// -----------------------------------------------------------------------------
module tb_tail_bytes_capture;

  localparam logic [55:0] PAD = 56'hffffffffffffff;

  logic         clk;
  logic         rst_n;
  logic         in_pkt_sop;
  logic         in_pkt_eop;
  logic         in_pkt_valid;
  logic [255:0] in_pkt_data;
  logic [4:0]   in_pkt_empty;
  logic         in_pkt_ready;
  logic [55:0]  last_7_bytes;
  logic         last_7_bytes_valid;
  logic         last_7_bytes_ready;

  int           n_compared   = 0;
  int           n_mismatched = 0;
  logic [55:0]  exp_q[$];

  tail_bytes_capture #(
    .DEPTH    (4),
    .PAD_BYTE (8'hff)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .in_pkt_sop         (in_pkt_sop),
    .in_pkt_eop         (in_pkt_eop),
    .in_pkt_valid       (in_pkt_valid),
    .in_pkt_data        (in_pkt_data),
    .in_pkt_empty       (in_pkt_empty),
    .in_pkt_ready       (in_pkt_ready),
    .last_7_bytes       (last_7_bytes),
    .last_7_bytes_valid (last_7_bytes_valid),
    .last_7_bytes_ready (last_7_bytes_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case some scenario wedges.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Byte-wise reference: last 7 bytes of (prefix bytes ++ valid flit bytes).
  function automatic logic [55:0] model_tail(input logic [255:0] d,
                                             input int          empty,
                                             input logic [55:0] prefix);
    logic [55:0] r;
    int          n;
    int          idx;
    r = '0;
    n = 32 - empty;
    for (int k = 0; k < 7; k++) begin
      idx = n - 7 + k;
      if (idx >= 0) r[55-8*k -: 8] = d[255-8*idx -: 8];
      else          r[55-8*k -: 8] = prefix[55-8*(7+idx) -: 8];
    end
    return r;
  endfunction

  function automatic logic [255:0] rand_flit();
    logic [255:0] d;
    for (int w = 0; w < 8; w++) d[32*w +: 32] = $urandom();
    return d;
  endfunction

  // Pops the head record (starting and ending just after a negedge).
  task automatic drain_one(input string name);
    logic [55:0] exp;
    n_compared++;
    if (last_7_bytes_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL %s valid: got %b want 1", name, last_7_bytes_valid);
    end
    n_compared++;
    if (exp_q.size() == 0) begin
      n_mismatched++;
      $display("[TB] FAIL %s scoreboard: got %h but no record expected", name, last_7_bytes);
    end else begin
      exp = exp_q.pop_front();
      if (last_7_bytes !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL %s data: got %h want %h", name, last_7_bytes, exp);
      end
    end
    last_7_bytes_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    last_7_bytes_ready = 1'b0;
  endtask

  // Drives one flit and holds it until accepted (bounded).
  task automatic send_flit(input logic sop, input logic eop,
                           input logic [255:0] data, input logic [4:0] empty,
                           input string name);
    int waited;
    in_pkt_sop   = sop;
    in_pkt_eop   = eop;
    in_pkt_data  = data;
    in_pkt_empty = empty;
    in_pkt_valid = 1'b1;
    waited = 0;
    while (in_pkt_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (in_pkt_ready !== 1'b1) begin
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s accept timeout: ready=%b want 1", name, in_pkt_ready);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_pkt_valid = 1'b0;
    in_pkt_sop   = 1'b0;
    in_pkt_eop   = 1'b0;
  endtask

  task automatic expect_empty(input string name);
    n_compared++;
    if (last_7_bytes_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL %s valid: got %b want 0", name, last_7_bytes_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_compared++;
    if (last_7_bytes_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_valid: got %b want 1", last_7_bytes_valid);
    end
    n_compared++;
    if (last_7_bytes !== PAD) begin
      n_mismatched++;
      $display("[TB] FAIL reset_data: got %h want %h", last_7_bytes, PAD);
    end
    n_compared++;
    if (in_pkt_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL reset_ready: got %b want 1", in_pkt_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_q.push_back(PAD);
    @(negedge clk);
    drain_one("seed_pop");
    expect_empty("empty_after_seed");
    // Popping an empty FIFO must not underflow the count.
    last_7_bytes_ready = 1'b1;
    repeat (2) @(negedge clk);
    last_7_bytes_ready = 1'b0;
    expect_empty("no_underflow");
    n_compared++;
    if (in_pkt_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL underflow_ready: got %b want 1", in_pkt_ready);
    end
  endtask

  task automatic test_two_flit();
    logic [255:0] d;
    d = {8{32'hcafef00d}};
    d[55:0] = 56'h11223344556677;
    send_flit(1'b1, 1'b0, d, 5'd9, "two_flit_f1");
    expect_empty("no_push_mid_packet");
    d = {8{32'h0badbeef}};
    d[55:0] = 56'haabbccddeeff00;
    exp_q.push_back(56'haabbccddeeff00);
    send_flit(1'b0, 1'b1, d, 5'd0, "two_flit_f2");
    drain_one("two_flit_tail");
    expect_empty("two_flit_drained");
  endtask

  task automatic test_partial_eop();
    logic [255:0] d;
    d = rand_flit();
    d[55:0] = 56'h11223344556677;
    send_flit(1'b1, 1'b0, d, 5'd17, "partial_f1");
    d = rand_flit();
    d[255:232] = 24'ha1a2a3;
    exp_q.push_back(56'h44556677a1a2a3);
    send_flit(1'b0, 1'b1, d, 5'd29, "partial_f2");
    drain_one("partial_tail");
  endtask

  task automatic test_short_single();
    logic [255:0] d;
    d = rand_flit();
    d[255:224] = 32'h01020304;
    exp_q.push_back(56'hffffff01020304);
    send_flit(1'b1, 1'b1, d, 5'd28, "short_single");
    drain_one("short_single_tail");
  endtask

  task automatic test_sop_restart();
    logic [255:0] d;
    d = rand_flit();
    d[55:0] = 56'h99999999999999;
    send_flit(1'b1, 1'b0, d, 5'd0, "restart_unterminated");
    d = rand_flit();
    d[255:240] = 16'hbbcc;
    exp_q.push_back(56'hffffffffffbbcc);
    send_flit(1'b1, 1'b1, d, 5'd30, "restart_new_pkt");
    // Eop-only flit right after an eop: previous tail must be pad again.
    d = rand_flit();
    d[255:248] = 8'h77;
    exp_q.push_back(56'hffffffffffff77);
    send_flit(1'b0, 1'b1, d, 5'd31, "eop_after_eop");
    drain_one("restart_tail");
    drain_one("eop_after_eop_tail");
    expect_empty("restart_drained");
  endtask

  task automatic test_random();
    logic [255:0] d;
    int           e;
    for (int round = 0; round < 2; round++) begin
      for (int i = 0; i < 3; i++) begin
        d = rand_flit();
        e = $urandom_range(0, 31);
        exp_q.push_back(model_tail(d, e, PAD));
        send_flit(1'b1, 1'b1, d, 5'(e), "random_pkt");
      end
      for (int i = 0; i < 3; i++) drain_one("random_tail");
    end
    expect_empty("random_drained");
  endtask

  task automatic test_full();
    logic [255:0] d;
    logic [55:0]  exp;
    for (int i = 0; i < 4; i++) begin
      d = rand_flit();
      d[255:248] = 8'h10 + 8'(i);
      exp_q.push_back({48'hffffffffffff, 8'h10 + 8'(i)});
      send_flit(1'b1, 1'b1, d, 5'd31, "fill_pkt");
    end
    n_compared++;
    if (in_pkt_ready !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL full_ready: got %b want 0", in_pkt_ready);
    end
    // Fifth packet is presented and must be held while full.
    d = rand_flit();
    d[255:248] = 8'h50;
    exp_q.push_back(56'hffffffffffff50);
    in_pkt_sop   = 1'b1;
    in_pkt_eop   = 1'b1;
    in_pkt_data  = d;
    in_pkt_empty = 5'd31;
    in_pkt_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_compared++;
      if (in_pkt_ready !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL held_ready: got %b want 0", in_pkt_ready);
      end
    end
    exp = exp_q.pop_front();
    n_compared++;
    if (last_7_bytes !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL full_head: got %h want %h", last_7_bytes, exp);
    end
    last_7_bytes_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    last_7_bytes_ready = 1'b0;
    n_compared++;
    if (in_pkt_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL ready_after_pop: got %b want 1", in_pkt_ready);
    end
    @(posedge clk);
    @(negedge clk);
    in_pkt_valid = 1'b0;
    in_pkt_sop   = 1'b0;
    in_pkt_eop   = 1'b0;
    for (int i = 0; i < 4; i++) drain_one("full_order");
    expect_empty("full_drained");
  endtask

  task automatic test_back_to_back();
    logic [255:0] d;
    logic [55:0]  exp;
    for (int i = 0; i < 2; i++) begin
      d = rand_flit();
      d[255:248] = 8'h20 + 8'(i);
      exp_q.push_back({48'hffffffffffff, 8'h20 + 8'(i)});
      send_flit(1'b1, 1'b1, d, 5'd31, "b2b_prefill");
    end
    // Simultaneous push and pop: count holds at 2 while both pointers wrap.
    for (int i = 0; i < 5; i++) begin
      exp = exp_q.pop_front();
      n_compared++;
      if (last_7_bytes !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_head: got %h want %h", last_7_bytes, exp);
      end
      d = rand_flit();
      d[255:240] = {8'h30 + 8'(i), 8'h5c};
      exp_q.push_back({40'hffffffffff, 8'h30 + 8'(i), 8'h5c});
      in_pkt_sop         = 1'b1;
      in_pkt_eop         = 1'b1;
      in_pkt_data        = d;
      in_pkt_empty       = 5'd30;
      in_pkt_valid       = 1'b1;
      last_7_bytes_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_pkt_valid       = 1'b0;
      last_7_bytes_ready = 1'b0;
      n_compared++;
      if (in_pkt_ready !== 1'b1) begin
        n_mismatched++;
        $display("[TB] FAIL b2b_ready: got %b want 1", in_pkt_ready);
      end
    end
    drain_one("b2b_rem0");
    drain_one("b2b_rem1");
    expect_empty("b2b_count_two");
  endtask

  task automatic test_reset_mid_packet();
    logic [255:0] d;
    d = rand_flit();
    d[255:248] = 8'h66;
    exp_q.push_back(56'hffffffffffff66);
    send_flit(1'b1, 1'b1, d, 5'd31, "pre_reset_pkt");
    d = rand_flit();
    d[55:0] = 56'h123456789abcde;
    send_flit(1'b1, 1'b0, d, 5'd0, "pre_reset_partial");
    #3;
    rst_n = 1'b0;
    #1;
    n_compared++;
    if (last_7_bytes !== PAD || last_7_bytes_valid !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_seed: got %h/%b want %h/1", last_7_bytes, last_7_bytes_valid, PAD);
    end
    n_compared++;
    if (in_pkt_ready !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_ready: got %b want 1", in_pkt_ready);
    end
    exp_q.delete();
    exp_q.push_back(PAD);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    // Continuation of the dropped packet must see pad, not the old bytes.
    d = rand_flit();
    d[255:240] = 16'hbbcc;
    exp_q.push_back(56'hffffffffffbbcc);
    send_flit(1'b0, 1'b1, d, 5'd30, "post_reset_eop");
    drain_one("post_reset_seed");
    drain_one("post_reset_tail");
    expect_empty("post_reset_drained");
  endtask

  initial begin
    rst_n              = 1'b0;
    in_pkt_sop         = 1'b0;
    in_pkt_eop         = 1'b0;
    in_pkt_valid       = 1'b0;
    in_pkt_data        = '0;
    in_pkt_empty       = '0;
    last_7_bytes_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_two_flit();
    test_partial_eop();
    test_short_single();
    test_sop_restart();
    test_random();
    test_full();
    test_back_to_back();
    test_reset_mid_packet();
    n_compared++;
    if (exp_q.size() != 0) begin
      n_mismatched++;
      $display("[TB] FAIL scoreboard_leftover: got %0d records want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
